// File: rtl/vram_arbiter.sv
// Two-port arbiter for the single-port video memory: the display fetch has priority,
// a run-length guard lets drawing through, and read data is routed back to the issuing port.
module vram_arbiter #(
   parameter int ADDR_W  = 24,
   parameter int DATA_W  = 24,
   parameter int RD_LAT  = 2,
   parameter int MAX_RUN = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic [DATA_W-1:0] disp_rdata,
   output logic              disp_rvalid,
   input  logic              draw_req,
   input  logic              draw_we,
   input  logic [ADDR_W-1:0] draw_addr,
   input  logic [DATA_W-1:0] draw_wdata,
   output logic              draw_gnt,
   output logic [DATA_W-1:0] draw_rdata,
   output logic              draw_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // state      | meaning
   // ARB        | display has priority, draw served only when display is idle
   // FORCE_DRAW | display run limit reached, draw has priority for one grant
   typedef enum logic {
      ARB        = 1'b0,
      FORCE_DRAW = 1'b1
   } state_t;

   localparam int RUN_W = $clog2(MAX_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_RUN);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_RUN - 1);

   state_t           state, state_nxt;
   logic [RUN_W-1:0] run_cnt, run_cnt_nxt;

   // port that issued the access currently on the memory bus (1 = draw)
   logic             mem_port;
   logic [RD_LAT-1:0] tag_vld;
   logic [RD_LAT-1:0] tag_port;

   always_comb begin
      disp_gnt    = 1'b0;
      draw_gnt    = 1'b0;
      state_nxt   = state;
      run_cnt_nxt = run_cnt;

      case (state)
         ARB: begin
            disp_gnt = disp_req;
            draw_gnt = draw_req & ~disp_req;
         end
         FORCE_DRAW: begin
            draw_gnt  = draw_req;
            disp_gnt  = disp_req & ~draw_req;
            // every cycle here either grants someone or sees both ports idle
            state_nxt = ARB;
         end
         default: state_nxt = ARB;
      endcase

      if (draw_gnt || !draw_req) begin
         run_cnt_nxt = '0;
      end else if (disp_gnt) begin
         if (state == ARB && run_cnt >= RUN_LAST) begin
            run_cnt_nxt = '0;
            state_nxt   = FORCE_DRAW;
         end else if (run_cnt != RUN_MAX) begin
            run_cnt_nxt = run_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ARB;
         run_cnt <= '0;
      end else begin
         state   <= state_nxt;
         run_cnt <= run_cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_port  <= 1'b0;
      end else begin
         mem_en <= disp_gnt | draw_gnt;
         mem_we <= draw_gnt & draw_we;
         if (disp_gnt) begin
            mem_addr <= disp_addr;
            mem_port <= 1'b0;
         end else if (draw_gnt) begin
            mem_addr  <= draw_addr;
            mem_wdata <= draw_wdata;
            mem_port  <= 1'b1;
         end
      end
   end

   // tag pipeline mirrors the memory latency so returning data knows its owner
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld  <= '0;
         tag_port <= '0;
      end else begin
         tag_vld[0]  <= mem_en & ~mem_we;
         tag_port[0] <= mem_port;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_vld[i]  <= tag_vld[i-1];
            tag_port[i] <= tag_port[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_rdata  <= '0;
         disp_rvalid <= 1'b0;
         draw_rdata  <= '0;
         draw_rvalid <= 1'b0;
      end else begin
         disp_rvalid <= tag_vld[RD_LAT-1] & ~tag_port[RD_LAT-1];
         draw_rvalid <= tag_vld[RD_LAT-1] & tag_port[RD_LAT-1];
         if (tag_vld[RD_LAT-1] && !tag_port[RD_LAT-1]) begin
            disp_rdata <= mem_rdata;
         end
         if (tag_vld[RD_LAT-1] && tag_port[RD_LAT-1]) begin
            draw_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_vram_arbiter;

   localparam int ADDR_W  = 24;
   localparam int DATA_W  = 24;
   localparam int RD_LAT  = 2;
   localparam int MAX_RUN = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              disp_gnt;
   logic [DATA_W-1:0] disp_rdata;
   logic              disp_rvalid;
   logic              draw_req;
   logic              draw_we;
   logic [ADDR_W-1:0] draw_addr;
   logic [DATA_W-1:0] draw_wdata;
   logic              draw_gnt;
   logic [DATA_W-1:0] draw_rdata;
   logic              draw_rvalid;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   vram_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT),
      .MAX_RUN(MAX_RUN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .disp_req   (disp_req),
      .disp_addr  (disp_addr),
      .disp_gnt   (disp_gnt),
      .disp_rdata (disp_rdata),
      .disp_rvalid(disp_rvalid),
      .draw_req   (draw_req),
      .draw_we    (draw_we),
      .draw_addr  (draw_addr),
      .draw_wdata (draw_wdata),
      .draw_gnt   (draw_gnt),
      .draw_rdata (draw_rdata),
      .draw_rvalid(draw_rvalid),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // memory environment: single-port RAM with RD_LAT read latency
   logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
   logic [DATA_W-1:0] rd_pipe [RD_LAT];

   function automatic logic [DATA_W-1:0] init_val(logic [ADDR_W-1:0] a);
      return DATA_W'(a + 24'h100);
   endfunction

   function automatic logic [DATA_W-1:0] mem_get(logic [ADDR_W-1:0] a);
      return mem.exists(a) ? mem[a] : init_val(a);
   endfunction

   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
      rd_pipe[0] <= (mem_en && !mem_we) ? mem_get(mem_addr) : DATA_W'($urandom);
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[RD_LAT-1];

   // reference model state
   typedef struct {
      int                due;
      logic [DATA_W-1:0] data;
   } rd_t;

   logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
   rd_t               q_disp[$];
   rd_t               q_draw[$];
   int                consec;
   int                cyc;
   logic              exp_en, exp_we;
   logic [ADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0] exp_wdata, exp_disp_rd, exp_draw_rd;
   logic              last_disp, last_draw;
   int                gnt_log[$];
   int                n_disp_rv, n_draw_rv;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h time=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] ref_get(logic [ADDR_W-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   function automatic void model_reset();
      q_disp.delete();
      q_draw.delete();
      consec      = 0;
      exp_en      = 1'b0;
      exp_we      = 1'b0;
      exp_addr    = '0;
      exp_wdata   = '0;
      exp_disp_rd = '0;
      exp_draw_rd = '0;
      last_disp   = 1'b0;
      last_draw   = 1'b0;
   endfunction

   // one clock cycle: check at negedge, update model, advance past posedge
   task automatic step();
      logic eg_disp, eg_draw;
      rd_t  r;
      @(negedge clk);
      eg_draw = draw_req && (consec >= MAX_RUN || !disp_req);
      eg_disp = disp_req && !eg_draw;

      check_val("disp_gnt", disp_gnt, eg_disp);
      check_val("draw_gnt", draw_gnt, eg_draw);
      check_val("mem_en", mem_en, exp_en);
      check_val("mem_we", mem_we, exp_we);
      check_val("mem_addr", mem_addr, exp_addr);
      if (exp_we) check_val("mem_wdata", mem_wdata, exp_wdata);

      if (q_disp.size() > 0 && q_disp[0].due == cyc) begin
         r = q_disp.pop_front();
         exp_disp_rd = r.data;
         check_val("disp_rvalid", disp_rvalid, 1);
      end else begin
         check_val("disp_rvalid", disp_rvalid, 0);
      end
      check_val("disp_rdata", disp_rdata, exp_disp_rd);

      if (q_draw.size() > 0 && q_draw[0].due == cyc) begin
         r = q_draw.pop_front();
         exp_draw_rd = r.data;
         check_val("draw_rvalid", draw_rvalid, 1);
      end else begin
         check_val("draw_rvalid", draw_rvalid, 0);
      end
      check_val("draw_rdata", draw_rdata, exp_draw_rd);

      if (disp_rvalid) n_disp_rv++;
      if (draw_rvalid) n_draw_rv++;

      exp_en = eg_disp || eg_draw;
      exp_we = eg_draw && draw_we;
      if (eg_disp) begin
         exp_addr = disp_addr;
         q_disp.push_back('{due: cyc + RD_LAT + 2, data: ref_get(disp_addr)});
      end else if (eg_draw) begin
         exp_addr = draw_addr;
         if (draw_we) begin
            exp_wdata = draw_wdata;
            ref_mem[draw_addr] = draw_wdata;
         end else begin
            q_draw.push_back('{due: cyc + RD_LAT + 2, data: ref_get(draw_addr)});
         end
      end

      if (eg_draw || !draw_req) consec = 0;
      else if (eg_disp) consec++;

      gnt_log.push_back(eg_disp ? 1 : (eg_draw ? 2 : 0));
      last_disp = eg_disp;
      last_draw = eg_draw;

      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic idle(int n);
      disp_req = 1'b0;
      draw_req = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      disp_req = 1'b0;
      draw_req = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int run, max_run;
      rst        = 1'b1;
      disp_req   = 1'b0;
      disp_addr  = '0;
      draw_req   = 1'b0;
      draw_we    = 1'b0;
      draw_addr  = '0;
      draw_wdata = '0;
      cyc        = 0;
      n_disp_rv  = 0;
      n_draw_rv  = 0;
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
      model_reset();
      #2;
      do_reset();

      // reset state
      check_val("rst_mem_wdata", mem_wdata, 0);
      check_val("rst_disp_rdata", disp_rdata, 0);

      // single display read with known data
      mem[24'h10]     = 24'hABCDEF;
      ref_mem[24'h10] = 24'hABCDEF;
      disp_req  = 1'b1;
      disp_addr = 24'h10;
      step();
      n_draw_rv = 0;
      idle(6);
      check_val("single_disp_data", disp_rdata, 24'hABCDEF);
      check_val("single_draw_rv", n_draw_rv, 0);

      // draw write then display read of the same address
      draw_req   = 1'b1;
      draw_we    = 1'b1;
      draw_addr  = 24'h5;
      draw_wdata = 24'h123456;
      step();
      draw_req  = 1'b0;
      disp_req  = 1'b1;
      disp_addr = 24'h5;
      step();
      idle(6);
      check_val("wr_then_rd", disp_rdata, 24'h123456);

      // both requesters saturating: 8 display, 1 draw, repeating
      do_reset();
      gnt_log.delete();
      disp_req  = 1'b1;
      disp_addr = 24'h40;
      draw_req  = 1'b1;
      draw_we   = 1'b0;
      draw_addr = 24'h41;
      for (int i = 0; i < 40; i++) step();
      idle(6);
      run = 0;
      max_run = 0;
      for (int i = 0; i < 40; i++) begin
         check_val("run_pattern", gnt_log[i], ((i % (MAX_RUN + 1)) < MAX_RUN) ? 1 : 2);
         run = (gnt_log[i] == 1) ? run + 1 : 0;
         if (run > max_run) max_run = run;
      end
      check_val("max_disp_run", max_run, MAX_RUN);

      // interleaved reads route to their own ports
      mem.delete();
      ref_mem.delete();
      disp_req  = 1'b1;
      disp_addr = 24'h10;
      step();
      disp_req  = 1'b0;
      draw_req  = 1'b1;
      draw_we   = 1'b0;
      draw_addr = 24'h20;
      step();
      idle(6);
      check_val("inter_disp", disp_rdata, 24'h110);
      check_val("inter_draw", draw_rdata, 24'h120);

      // reset discards in-flight reads
      for (int i = 0; i < 4; i++) begin
         disp_req  = 1'b1;
         disp_addr = ADDR_W'(24'h60 + i);
         step();
      end
      disp_req = 1'b0;
      step();
      do_reset();
      n_disp_rv = 0;
      n_draw_rv = 0;
      idle(8);
      check_val("post_rst_disp_rv", n_disp_rv, 0);
      check_val("post_rst_draw_rv", n_draw_rv, 0);
      check_val("post_rst_wdata", mem_wdata, 0);

      // draw alone, five back-to-back reads
      n_draw_rv = 0;
      gnt_log.delete();
      for (int i = 0; i < 5; i++) begin
         draw_req  = 1'b1;
         draw_we   = 1'b0;
         draw_addr = ADDR_W'(24'h30 + i);
         step();
      end
      idle(6);
      check_val("draw_only_rv", n_draw_rv, 5);
      for (int i = 0; i < 5; i++) check_val("draw_only_gnt", gnt_log[i], 2);

      // randomized traffic with request hold / drop protocol
      for (int n = 0; n < 3000; n++) begin
         if (!(disp_req && !last_disp && $urandom_range(9) != 0)) begin
            disp_req  = ($urandom_range(3) != 0);
            disp_addr = ADDR_W'($urandom_range(15));
         end
         if (!(draw_req && !last_draw && $urandom_range(9) != 0)) begin
            draw_req   = ($urandom_range(1) != 0);
            draw_we    = ($urandom_range(1) != 0);
            draw_addr  = ADDR_W'($urandom_range(15));
            draw_wdata = DATA_W'($urandom);
         end
         step();
      end
      idle(8);
      check_val("drain_disp_q", q_disp.size(), 0);
      check_val("drain_draw_q", q_draw.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Two-requester arbiter for the single-port video memory. It sits between the memory and its two users. The display fetcher streams pixel words into the VGA line FIFO, and the drawing engine reads and writes note graphics. The display port gets priority so the FIFO never starves. A run-length guard guarantees the drawing engine forward progress, and returning read data is routed back to whichever port issued the read.

## Interface
Parameters:
- ADDR_W, 24, address width.
- DATA_W, 24, data word width.
- RD_LAT, 2, memory read latency in cycles from mem_en (≥1).
- MAX_RUN, 8, maximum consecutive display grants while draw_req is pending (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- disp_req  in  1  display read request.
- disp_addr  in  ADDR_W  display read address.
- disp_gnt  out  1  display request accepted this cycle.
- disp_rdata  out  DATA_W  display read data.
- disp_rvalid  out  1  disp_rdata valid, one-cycle pulse per accepted read.
- draw_req  in  1  drawing request.
- draw_we  in  1  1 = write, 0 = read.
- draw_addr  in  ADDR_W  drawing address.
- draw_wdata  in  DATA_W  drawing write data.
- draw_gnt  out  1  drawing request accepted this cycle.
- draw_rdata  out  DATA_W  drawing read data.
- draw_rvalid  out  1  draw_rdata valid, pulses for reads only.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after a read mem_en.

## Operation
- Handshake: a transfer occurs on any cycle where req && gnt. The requester holds addr, wdata and we stable while req is high and not granted. Grants are combinational from req and arbiter state. At most one of disp_gnt and draw_gnt is high per cycle.
- FSM states:
  - ARB: disp_req wins if present, otherwise draw_req.
  - FORCE_DRAW: draw_req wins if present, otherwise disp_req. Exits to ARB after any grant or when both requests are low.
- Run counter run_cnt, width $clog2(MAX_RUN+1):
  - Increments on each disp grant while draw_req is high.
  - Clears on any draw grant and whenever draw_req is low.
  - In ARB, when a disp grant takes run_cnt to MAX_RUN, the next state is FORCE_DRAW and run_cnt clears.
  - run_cnt saturates and never wraps.
- Memory command: the accepted transaction is registered into mem_en, mem_we, mem_addr and mem_wdata. mem_en is high for exactly the one cycle after the grant. With no grant, mem_en=0 and mem_we=0; addr and wdata hold their last values.
- Read return: a tag pipeline of depth RD_LAT carries {valid, port} from each read mem_en.
  - At the pipeline output, mem_rdata is registered to the owning port's rdata and its rvalid pulses.
  - The other port's rdata holds its previous value.
  - Writes insert no tag.
- Ordering: read data returns in issue order per port. Pipelined back-to-back reads are allowed, one per cycle.
- No read/write hazard checking. A draw write followed by a display read to the same address sees the new data, because the memory is single-port and accesses are serialized in grant order.

## Timing
- Reset values: all outputs 0, state ARB, run_cnt 0, tag pipeline cleared.
- Reset asserted mid-operation: in-flight reads are discarded, and no rvalid pulses after reset deasserts for reads issued before it.
- Latency: grant at cycle T gives mem_en at T+1 and rvalid at T+1+RD_LAT+1, i.e. T+RD_LAT+2.
- Throughput: one access per cycle sustained.
- Simultaneous requests in ARB with run_cnt < MAX_RUN-1: disp wins.
- After MAX_RUN consecutive disp grants with draw_req high throughout, the very next cycle is a draw grant even if disp_req is high.
- A request deasserted before its grant is dropped with no side effects.

## Test plan
- Reset, then a single disp read of addr 0x000010 with the memory model returning 0xABCDEF: disp_gnt at T, mem_en=1 with mem_addr=0x000010 at T+1, disp_rvalid with 0xABCDEF at T+4 (RD_LAT=2). draw_rvalid stays 0.
- draw write to 0x000005 with data 0x123456, then disp read of 0x000005: mem_we=1 for exactly one cycle, disp read returns 0x123456.
- disp_req and draw_req both held high for 40 cycles (MAX_RUN=8): grant pattern is 8 disp, 1 draw, repeating. Never 9 consecutive disp grants.
- Interleaved disp read of 0x10 and draw read of 0x20 on consecutive cycles, memory returning addr+0x100: disp receives 0x110 and draw receives 0x120, one cycle apart, with no cross-routing.
- Four back-to-back disp reads, then rst pulsed one cycle after the last grant: after release, zero rvalid pulses and all outputs 0.
- draw_req alone, held 5 cycles with reads: 5 consecutive draw grants and 5 draw_rvalid pulses in order.
